// File: rtl/alien_fleet_if.sv
// alien_fleet_if: game-side inputs and fleet outputs of the alien fleet sequencer.
// master drives game state and alive rows; slave is the fleet controller.
interface alien_fleet_if;
    logic       frame_tick;
    logic [2:0] curr_state;
    logic [6:0] row_a;
    logic [6:0] row_b;
    logic [6:0] row_c;
    logic [9:0] fleet_x;
    logic [9:0] fleet_y;
    logic       step;
    logic       anim_frame;
    logic       wave_clear;
    logic       invaded;

    modport master (
        output frame_tick, curr_state, row_a, row_b, row_c,
        input  fleet_x, fleet_y, step, anim_frame, wave_clear, invaded
    );

    modport slave (
        input  frame_tick, curr_state, row_a, row_b, row_c,
        output fleet_x, fleet_y, step, anim_frame, wave_clear, invaded
    );
endinterface

// File: rtl/alien_fleet_ctrl.sv
// alien_fleet_ctrl: marches the 3x7 alien wave, detects wave clear and invasion.
// Optional FLEET_SPEEDUP_EN: step period shrinks as aliens die.
module alien_fleet_ctrl (
    input  logic         Clk,
    input  logic         Reset,
    alien_fleet_if.slave bus
);
    localparam logic [2:0] PLAY_STATE = 3'd1;
    localparam logic [9:0] X_START    = 10'd20;
    localparam logic [9:0] Y_START    = 10'd40;
    localparam logic [9:0] X_LEFT     = 10'd10;
    localparam logic [9:0] X_RIGHT    = 10'd630;
    localparam logic [9:0] WAVE_W     = 10'd201;
    localparam logic [9:0] STEP_X     = 10'd4;
    localparam logic [9:0] STEP_Y     = 10'd12;
    localparam logic [9:0] Y_INVADE   = 10'd400;
`ifdef FLEET_SPEEDUP_EN
    localparam logic [5:0] MIN_FRAMES = 6'd4;
`else
    localparam logic [5:0] BASE_FRAMES = 6'd25;
`endif

    typedef enum logic [1:0] {IDLE, MARCH_R, MARCH_L, HALT} state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [9:0]  r_x;
    logic [9:0]  w_x_nx;
    logic [9:0]  r_y;
    logic [9:0]  w_y_nx;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nx;
    logic        r_step;
    logic        w_step_nx;
    logic        r_anim;
    logic        w_anim_nx;
    logic        r_wc;
    logic        w_wc_nx;
    logic        r_inv;
    logic        w_inv_nx;
    logic [20:0] w_rows;
    logic [4:0]  w_alive;
    logic [5:0]  w_period;
    logic        w_init;
    logic        w_play;
    logic        w_due;
    logic        w_edge_r;
    logic        w_edge_l;
    logic        w_drop;
    logic [10:0] w_y_drop;

    assign w_rows  = {bus.row_a, bus.row_b, bus.row_c};
    assign w_alive = 5'($countones(w_rows));

`ifdef FLEET_SPEEDUP_EN
    assign w_period = MIN_FRAMES + {1'b0, w_alive};
`else
    assign w_period = BASE_FRAMES;
`endif

    assign w_init = (bus.curr_state == 3'd0) ||
                    (bus.curr_state == 3'd5) ||
                    (bus.curr_state == 3'd6);
    assign w_play = (bus.curr_state == PLAY_STATE);

    // >= rather than == so a period that shrank below the count fires at once
    assign w_due = bus.frame_tick && (r_cnt >= w_period - 6'd1);

    assign w_edge_r = ({1'b0, r_x} + {1'b0, WAVE_W} + {1'b0, STEP_X})
                      > {1'b0, X_RIGHT};
    assign w_edge_l = {1'b0, r_x} < ({1'b0, X_LEFT} + {1'b0, STEP_X});
    assign w_drop   = (r_state == MARCH_R) ? w_edge_r : w_edge_l;
    assign w_y_drop = {1'b0, r_y} + {1'b0, STEP_Y};

    always_comb begin
        w_state_nx = r_state;
        w_x_nx     = r_x;
        w_y_nx     = r_y;
        w_cnt_nx   = r_cnt;
        w_step_nx  = 1'b0;
        w_anim_nx  = r_anim;
        w_wc_nx    = r_wc;
        w_inv_nx   = r_inv;
        if (w_init) begin
            w_state_nx = IDLE;
            w_x_nx     = X_START;
            w_y_nx     = Y_START;
            w_cnt_nx   = 6'd0;
            w_anim_nx  = 1'b0;
            w_wc_nx    = 1'b0;
            w_inv_nx   = 1'b0;
        end else if (w_play) begin
            unique case (r_state)
                IDLE: begin
                    if (w_alive == 5'd0) begin
                        w_wc_nx    = 1'b1;
                        w_state_nx = HALT;
                    end else begin
                        w_state_nx = MARCH_R;
                    end
                end
                MARCH_R, MARCH_L: begin
                    if (w_alive == 5'd0) begin
                        w_wc_nx    = 1'b1;
                        w_state_nx = HALT;
                    end else if (w_due) begin
                        w_cnt_nx  = 6'd0;
                        w_step_nx = 1'b1;
                        w_anim_nx = ~r_anim;
                        if (w_drop) begin
                            w_y_nx     = w_y_drop[9:0];
                            w_state_nx = (r_state == MARCH_R) ? MARCH_L : MARCH_R;
                            if (w_y_drop >= {1'b0, Y_INVADE}) begin
                                w_inv_nx   = 1'b1;
                                w_state_nx = HALT;
                            end
                        end else if (r_state == MARCH_R) begin
                            w_x_nx = r_x + STEP_X;
                        end else begin
                            w_x_nx = r_x - STEP_X;
                        end
                    end else if (bus.frame_tick) begin
                        w_cnt_nx = r_cnt + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_x     <= X_START;
            r_y     <= Y_START;
            r_cnt   <= 6'd0;
            r_step  <= 1'b0;
            r_anim  <= 1'b0;
            r_wc    <= 1'b0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_x     <= w_x_nx;
            r_y     <= w_y_nx;
            r_cnt   <= w_cnt_nx;
            r_step  <= w_step_nx;
            r_anim  <= w_anim_nx;
            r_wc    <= w_wc_nx;
            r_inv   <= w_inv_nx;
        end
    end

    assign bus.fleet_x    = r_x;
    assign bus.fleet_y    = r_y;
    assign bus.step       = r_step;
    assign bus.anim_frame = r_anim;
    assign bus.wave_clear = r_wc;
    assign bus.invaded    = r_inv;
endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// tb_alien_fleet_ctrl: random and directed stimulus for alien_fleet_ctrl,
// checked each cycle against a behavioural fleet model.
`timescale 1ns/1ps
module tb_alien_fleet_ctrl;
    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef FLEET_SPEEDUP_EN
    localparam int ONE_ALIEN_P = 5;
`else
    localparam int ONE_ALIEN_P = 25;
`endif

    alien_fleet_if bus ();

    alien_fleet_ctrl dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int x;
        int y;
        int dir;
        int cnt;
        bit started;
        bit halted;
        bit step;
        bit anim;
        bit wc;
        bit inv;
    } model_t;

    model_t m;

    function automatic model_t m_init();
        model_t s;
        s.x = 20;   s.y = 40;   s.dir = 1;   s.cnt = 0;
        s.started = 0; s.halted = 0; s.step = 0;
        s.anim = 0; s.wc = 0; s.inv = 0;
        return s;
    endfunction

    function automatic model_t model_next(model_t s, logic tick,
                                          logic [2:0] cs, logic [20:0] rows);
        model_t n = s;
        int alive;
        int p;
        bit hit_edge;
        n.step = 0;
        if (cs == 0 || cs == 5 || cs == 6) return m_init();
        if (cs != 1 || s.halted) return n;
        alive = $countones(rows);
        if (alive == 0) begin
            n.wc = 1;
            n.halted = 1;
            return n;
        end
        if (!s.started) begin
            n.started = 1;
            return n;
        end
        if (!tick) return n;
`ifdef FLEET_SPEEDUP_EN
        p = 4 + alive;
`else
        p = 25;
`endif
        if (s.cnt + 1 < p) begin
            n.cnt = s.cnt + 1;
            return n;
        end
        n.cnt  = 0;
        n.step = 1;
        n.anim = !s.anim;
        // right edge = x + width; moving must keep it within 630 / x within 10
        hit_edge = (s.dir > 0) ? (s.x + 201 + 4 > 630) : (s.x - 4 < 10);
        if (hit_edge) begin
            n.y   = s.y + 12;
            n.dir = -s.dir;
            if (n.y >= 400) begin
                n.inv = 1;
                n.halted = 1;
            end
        end else begin
            n.x = s.x + 4 * s.dir;
        end
        return n;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) m <= m_init();
        else m <= model_next(m, bus.frame_tick, bus.curr_state,
                             {bus.row_a, bus.row_b, bus.row_c});
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        chk("m_x", int'(bus.fleet_x), m.x);
        chk("m_y", int'(bus.fleet_y), m.y);
        chk("m_step", int'(bus.step), int'(m.step));
        chk("m_anim", int'(bus.anim_frame), int'(m.anim));
        chk("m_wc", int'(bus.wave_clear), int'(m.wc));
        chk("m_inv", int'(bus.invaded), int'(m.inv));
    end

    task automatic pulse(int gap);
        repeat (gap - 1) @(negedge Clk);
        bus.frame_tick = 1'b1;
        @(negedge Clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic set_rows(logic [6:0] a, logic [6:0] b, logic [6:0] c);
        bus.row_a = a;
        bus.row_b = b;
        bus.row_c = c;
    endtask

    initial begin
        int n;
        int r;
        bus.frame_tick = 1'b0;
        bus.curr_state = 3'd0;
        set_rows(7'h7F, 7'h7F, 7'h7F);
        repeat (3) @(negedge Clk);
        chk("rst_x", bus.fleet_x, 20);
        chk("rst_y", bus.fleet_y, 40);
        chk("rst_step", bus.step, 0);
        chk("rst_anim", bus.anim_frame, 0);
        chk("rst_wc", bus.wave_clear, 0);
        chk("rst_inv", bus.invaded, 0);

        Reset = 1'b1;
        bus.curr_state = 3'd1;
        @(negedge Clk);
        for (int i = 0; i < 24; i++) pulse(10);
        chk("pre_step", bus.step, 0);
        chk("pre_x", bus.fleet_x, 20);
        pulse(10);
        chk("s1_step", bus.step, 1);
        chk("s1_x", bus.fleet_x, 24);
        chk("s1_anim", bus.anim_frame, 1);
        @(negedge Clk);
        chk("s1_pulse_len", bus.step, 0);

        repeat (10) pulse(1);
        bus.curr_state = 3'd2;
        repeat (100) pulse(1);
        chk("pause_x", bus.fleet_x, 24);
        chk("pause_y", bus.fleet_y, 40);
        bus.curr_state = 3'd1;
        repeat (14) pulse(1);
        chk("resume_x", bus.fleet_x, 24);
        pulse(1);
        chk("resume_step", bus.step, 1);
        chk("resume_x2", bus.fleet_x, 28);

        bus.curr_state = 3'd5;
        @(negedge Clk);
        chk("init_x", bus.fleet_x, 20);
        chk("init_y", bus.fleet_y, 40);
        chk("init_anim", bus.anim_frame, 0);

        bus.curr_state = 3'd1;
        @(negedge Clk);
        repeat (24) pulse(1);
        set_rows(7'h00, 7'h00, 7'h00);
        pulse(1);
        chk("wc_flag", bus.wave_clear, 1);
        chk("wc_step", bus.step, 0);
        chk("wc_x", bus.fleet_x, 20);
        set_rows(7'h7F, 7'h7F, 7'h7F);
        repeat (30) pulse(1);
        chk("wc_hold_x", bus.fleet_x, 20);
        chk("wc_sticky", bus.wave_clear, 1);
        chk("wc_inv", bus.invaded, 0);
        bus.curr_state = 3'd0;
        @(negedge Clk);
        chk("wc_cleared", bus.wave_clear, 0);

        set_rows(7'h00, 7'h08, 7'h00);
        bus.curr_state = 3'd1;
        @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (n < 60 && !bus.step) begin
                pulse(1);
                n++;
            end
            chk("one_alien_period", n, ONE_ALIEN_P);
            @(negedge Clk);
        end

        repeat (ONE_ALIEN_P - 1) pulse(1);
        bus.frame_tick = 1'b1;
        @(posedge Clk);
        #2 Reset = 1'b0;
        bus.frame_tick = 1'b0;
        #1;
        chk("midrst_x", bus.fleet_x, 20);
        chk("midrst_step", bus.step, 0);
        chk("midrst_anim", bus.anim_frame, 0);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 88) bus.curr_state = 3'd1;
            else if (r < 97) bus.curr_state = 3'($urandom_range(2, 4));
            else if (r < 98) bus.curr_state = 3'd7;
            else bus.curr_state = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) set_rows(7'h00, 7'h00, 7'h00);
            else set_rows(7'($urandom & $urandom), 7'($urandom), 7'($urandom | 1));
            @(negedge Clk);
        end

        bus.frame_tick = 1'b0;
        bus.curr_state = 3'd6;
        set_rows(7'h7F, 7'h7F, 7'h7F);
        @(negedge Clk);
        bus.curr_state = 3'd1;
        @(negedge Clk);
        bus.frame_tick = 1'b1;
        n = 0;
        while (!bus.invaded && n < 90000) begin
            @(negedge Clk);
            n++;
        end
        bus.frame_tick = 1'b0;
        chk("inv_flag", bus.invaded, 1);
        chk("inv_y", bus.fleet_y, 400);
        chk("inv_x", bus.fleet_x, 12);
        chk("inv_wc", bus.wave_clear, 0);
        chk("inv_anim", bus.anim_frame, 0);
        repeat (50) pulse(1);
        chk("inv_frozen_x", bus.fleet_x, 12);
        chk("inv_frozen_y", bus.fleet_y, 400);
        chk("inv_frozen_step", bus.step, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
